retire_store_buffer: RTL and testbench
======================================

RETIRE_STORE_BUFFER -- requirements
Module: retire_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entry count (power of 2, >=2).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have retire_valid  input  1  ROB head retiring this cycle.
REQ-005 SHALL have retire_store_ready  input  1  retiring head is a store with address and data ready.
REQ-006 SHALL have retire_store_addr  input  32  store byte address.
REQ-007 SHALL have retire_store_data  input  32  store data (rs2 value).
REQ-008 SHALL have retire_func3  input  3  store width: 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have store_executed  output  1  store accepted this cycle (retire_bus handshake back to ROB).
REQ-010 SHALL have mem_wr_en  output  1  data-memory write request.
REQ-011 SHALL have mem_addr  output  32  word address ({addr[31:2],2'b00}).
REQ-012 SHALL have mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have mem_byte_en  output  4  byte lane enables.
REQ-014 SHALL have mem_wr_ack  input  1  memory completed the presented write.
REQ-015 SHALL have ld_addr  input  32  load address for forwarding lookup.
REQ-016 SHALL have ld_fwd_hit, ld_fwd_conflict  output  1 each; ld_fwd_data  output  32.
REQ-017 SHALL have sb_empty, sb_full  output  1 each  buffer status.

Function
REQ-018 SHALL accept (push) when retire_valid & retire_store_ready & !sb_full; store_executed SHALL equal that condition combinationally, same cycle.
REQ-019 SHALL use registered occupancy for sb_full; a pop in the same cycle SHALL NOT permit a push into a full buffer.
REQ-020 SHALL hold store_executed low while full; ROB keeps request asserted until accepted; no request SHALL be dropped or duplicated.
REQ-021 SHALL encode entries at push: SB byte_en=1<<addr[1:0], data byte replicated to all lanes; SH byte_en=addr[1]?1100:0011, halfword replicated; SW byte_en=1111, addr[1:0] ignored.
REQ-022 SHALL treat func3 values other than 000/001/010 as SW.
REQ-023 SHALL implement FIFO with wrap-around read/write pointers of log2(DEPTH) bits plus count of log2(DEPTH)+1 bits.
REQ-024 SHALL implement FSM IDLE/WRITE: IDLE->WRITE when buffer non-empty; WRITE drives head entry with mem_wr_en=1, holds stable until mem_wr_ack.
REQ-025 SHALL pop head on mem_wr_ack in WRITE; stay WRITE if count after pop >0 (next entry presented next cycle), else IDLE.
REQ-026 SHALL give latency push at cycle N -> mem_wr_en high at N+1 when buffer was empty and FSM IDLE.
REQ-027 SHALL allow push and pop in the same cycle; count unchanged.
REQ-028 SHALL drive mem_wr_en=0, mem_addr/mem_wdata/mem_byte_en=0 in IDLE.
REQ-029 SHALL ignore retire flush: retired stores are architectural and SHALL all drain.
REQ-030 SHALL compare ld_addr[31:2] against all valid entries (including head in flight), selecting youngest match.
REQ-031 SHALL set ld_fwd_hit=1, ld_fwd_data=entry data when youngest match has byte_en 1111; ld_fwd_conflict=1 when youngest match partial; both 0, data 0 when no match.
REQ-032 SHALL evaluate forwarding combinationally on current-cycle state (push in same cycle not visible).

Reset
REQ-033 SHALL on rst_n=0 at a clock edge clear pointers, count, FSM to IDLE, entries invalid; outputs: store_executed 0 (combinational on full=0), mem_* 0, ld_fwd_* 0, sb_empty 1, sb_full 0.
REQ-034 SHALL abandon an in-flight write on reset mid-operation; mem_wr_en 0 the cycle after reset edge.

Verification
REQ-035 SW 0x100, data 0xDEADBEEF, ack after 2 cycles -> store_executed same cycle, mem_wr_en next cycle, addr 0x100, be 1111, held 2 cycles, then IDLE, sb_empty 1.
REQ-036 SB addr 0x203 data 0x000000A5 -> mem_addr 0x200, be 1000, wdata 0xA5A5A5A5; SH addr 0x302 data 0x1234 -> be 1100, wdata 0x12341234.
REQ-037 Ack held 0, 5 requests with DEPTH=4 -> 4 accepted, sb_full 1, 5th store_executed 0 until first ack, accepted the cycle after.
REQ-038 SW 0x40=0x11111111 then SW 0x40=0x22222222 buffered, ld_addr 0x40 -> hit 1, data 0x22222222; then SB 0x41 -> conflict 1, hit 0.
REQ-039 Push and ack same cycle with count 2 -> count stays 2, FIFO order preserved across pointer wrap over 10 stores.
REQ-040 rst_n low during WRITE with 3 entries -> next cycle mem_wr_en 0, sb_empty 1, no further writes.

Source files
------------

// File: rtl/retire_store_buffer.sv
// rtl/retire_store_buffer.sv - retired-store FIFO that drains to data memory and forwards to loads
// Stores are lane-encoded on entry; the head is presented until acked.
module retire_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire_valid,
    input  logic        retire_store_ready,
    input  logic [31:0] retire_store_addr,
    input  logic [31:0] retire_store_data,
    input  logic [2:0]  retire_func3,
    output logic        store_executed,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_wr_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_fwd_hit,
    output logic        ld_fwd_conflict,
    output logic [31:0] ld_fwd_data,
    output logic        sb_empty,
    output logic        sb_full
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [29:0]      addr_q [DEPTH];
    logic [29:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];

    logic             push, pop;
    logic [3:0]       enc_be;
    logic [31:0]      enc_data;
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_bits;

    assign unused_ld_bits = ^ld_addr[1:0];

    assign sb_full        = (count_q == (PTR_W+1)'(DEPTH));
    assign sb_empty       = (count_q == '0);
    assign push           = retire_valid & retire_store_ready & ~sb_full;
    assign pop            = (state_q == S_WRITE) & mem_wr_ack;
    assign store_executed = push;

    // Narrow stores are replicated across lanes so memory only needs byte enables.
    always_comb begin
        enc_be   = 4'hF;
        enc_data = retire_store_data;
        case (retire_func3)
            3'b000: begin
                enc_be   = 4'b0001 << retire_store_addr[1:0];
                enc_data = {4{retire_store_data[7:0]}};
            end
            3'b001: begin
                enc_be   = retire_store_addr[1] ? 4'b1100 : 4'b0011;
                enc_data = {2{retire_store_data[15:0]}};
            end
            default: begin
                enc_be   = 4'hF;
                enc_data = retire_store_data;
            end
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            addr_d[wr_ptr_q] = retire_store_addr[31:2];
            data_d[wr_ptr_q] = enc_data;
            be_d[wr_ptr_q]   = enc_be;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // Entering WRITE on the push cycle gives single-cycle latency from an empty buffer.
    always_comb begin
        state_d     = state_q;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = '0;
        case (state_q)
            S_IDLE: begin
                if (count_d != '0) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_addr    = {addr_q[rd_ptr_q], 2'b00};
                mem_wdata   = data_q[rd_ptr_q];
                mem_byte_en = be_q[rd_ptr_q];
                if (pop && count_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        ld_fwd_hit      = 1'b0;
        ld_fwd_conflict = 1'b0;
        ld_fwd_data     = '0;
        fwd_idx         = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (addr_q[fwd_idx] == ld_addr[31:2])) begin
                ld_fwd_hit      = (be_q[fwd_idx] == 4'hF);
                ld_fwd_conflict = (be_q[fwd_idx] != 4'hF);
                ld_fwd_data     = (be_q[fwd_idx] == 4'hF) ? data_q[fwd_idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end
endmodule

// File: tb/tb_retire_store_buffer.sv
// tb/tb_retire_store_buffer.sv - directed and randomized checks of retire_store_buffer against a queue model
module tb_retire_store_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic        retire_store_ready;
    logic [31:0] retire_store_addr;
    logic [31:0] retire_store_data;
    logic [2:0]  retire_func3;
    logic        store_executed;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_wr_ack;
    logic [31:0] ld_addr;
    logic        ld_fwd_hit;
    logic        ld_fwd_conflict;
    logic [31:0] ld_fwd_data;
    logic        sb_empty;
    logic        sb_full;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    retire_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .retire_valid(retire_valid), .retire_store_ready(retire_store_ready),
        .retire_store_addr(retire_store_addr), .retire_store_data(retire_store_data),
        .retire_func3(retire_func3), .store_executed(store_executed),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_wr_ack(mem_wr_ack), .ld_addr(ld_addr),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_conflict(ld_fwd_conflict), .ld_fwd_data(ld_fwd_data),
        .sb_empty(sb_empty), .sb_full(sb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic ent_t encode(logic [31:0] a, logic [31:0] d, logic [2:0] f3);
        ent_t e;
        e.wa = a[31:2];
        if (f3 == 3'b000) begin
            e.be = 4'h0;
            e.be[a[1:0]] = 1'b1;
            e.d  = d[7:0] * 32'h01010101;
        end else if (f3 == 3'b001) begin
            e.be = (a[1] == 1'b1) ? 4'hC : 4'h3;
            e.d  = d[15:0] * 32'h00010001;
        end else begin
            e.be = 4'hF;
            e.d  = d;
        end
        return e;
    endfunction

    function automatic logic [33:0] model_fwd(logic [31:0] la);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].wa == la[31:2]) begin
                if (sb[i].be == 4'hF) return {2'b10, sb[i].d};
                return {2'b01, 32'h0};
            end
        end
        return 34'h0;
    endfunction

    task automatic tick();
        bit   rst_seen, do_push, do_pop;
        ent_t e;
        rst_seen = !rst_n;
        do_push  = retire_valid && retire_store_ready && (sb.size() < DEPTH);
        do_pop   = (sb.size() != 0) && mem_wr_ack;
        e = encode(retire_store_addr, retire_store_data, retire_func3);
        @(posedge clk);
        #1;
        if (rst_seen) begin
            sb.delete();
        end else begin
            if (do_pop) sb.delete(0);
            if (do_push) sb.push_back(e);
        end
    endtask

    task automatic set_store(logic [31:0] a, logic [31:0] d, logic [2:0] f3);
        retire_valid       = 1'b1;
        retire_store_ready = 1'b1;
        retire_store_addr  = a;
        retire_store_data  = d;
        retire_func3       = f3;
    endtask

    task automatic idle_in();
        retire_valid       = 1'b0;
        retire_store_ready = 1'b0;
        retire_store_addr  = 32'h0;
        retire_store_data  = 32'h0;
        retire_func3       = 3'b010;
        mem_wr_ack         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        ld_addr = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({store_executed, mem_wr_en, mem_addr, mem_wdata, mem_byte_en} !== 70'h0)
            $display("FAIL reset_mem got se=%b wen=%b addr=%h wd=%h be=%h exp all 0",
                     store_executed, mem_wr_en, mem_addr, mem_wdata, mem_byte_en);
        else n_pass++;
        n_total++;
        if ({ld_fwd_hit, ld_fwd_conflict, ld_fwd_data, sb_empty, sb_full} !== {34'h0, 2'b10})
            $display("FAIL reset_status got hit=%b conf=%b data=%h empty=%b full=%b exp 0 0 0 1 0",
                     ld_fwd_hit, ld_fwd_conflict, ld_fwd_data, sb_empty, sb_full);
        else n_pass++;
    endtask

    task automatic test_sw_basic();
        set_store(32'h100, 32'hDEADBEEF, 3'b010);
        #1;
        n_total++;
        if (store_executed !== 1'b1 || mem_wr_en !== 1'b0)
            $display("FAIL sw_accept got se=%b wen=%b exp se=1 wen=0", store_executed, mem_wr_en);
        else n_pass++;
        tick();
        idle_in();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) mem_wr_ack = 1'b1;
            #1;
            n_total++;
            if ({mem_wr_en, mem_addr, mem_byte_en, mem_wdata} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF})
                $display("FAIL sw_write cyc%0d got wen=%b addr=%h be=%h wd=%h exp 1 00000100 f deadbeef",
                         c, mem_wr_en, mem_addr, mem_byte_en, mem_wdata);
            else n_pass++;
            tick();
        end
        idle_in();
        #1;
        n_total++;
        if (mem_wr_en !== 1'b0 || sb_empty !== 1'b1 || mem_addr !== 32'h0)
            $display("FAIL sw_idle got wen=%b empty=%b addr=%h exp 0 1 0", mem_wr_en, sb_empty, mem_addr);
        else n_pass++;
    endtask

    task automatic test_encoding();
        logic [31:0] a_tab  [3] = '{32'h203, 32'h302, 32'h403};
        logic [31:0] d_tab  [3] = '{32'h000000A5, 32'h00001234, 32'hCAFEF00D};
        logic [2:0]  f_tab  [3] = '{3'b000, 3'b001, 3'b111};
        logic [31:0] ea_tab [3] = '{32'h200, 32'h300, 32'h400};
        logic [31:0] ed_tab [3] = '{32'hA5A5A5A5, 32'h12341234, 32'hCAFEF00D};
        logic [3:0]  eb_tab [3] = '{4'b1000, 4'b1100, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            set_store(a_tab[k], d_tab[k], f_tab[k]);
            tick();
            idle_in();
            mem_wr_ack = 1'b1;
            #1;
            n_total++;
            if ({mem_wr_en, mem_addr, mem_byte_en, mem_wdata} !== {1'b1, ea_tab[k], eb_tab[k], ed_tab[k]})
                $display("FAIL encode%0d got wen=%b addr=%h be=%b wd=%h exp 1 %h %b %h",
                         k, mem_wr_en, mem_addr, mem_byte_en, mem_wdata, ea_tab[k], eb_tab[k], ed_tab[k]);
            else n_pass++;
            tick();
            idle_in();
        end
    endtask

    task automatic test_full();
        idle_in();
        for (int c = 0; c < 4; c++) begin
            set_store(32'h500 + 32'(4 * c), 32'(c), 3'b010);
            #1;
            n_total++;
            if (store_executed !== 1'b1)
                $display("FAIL full_fill%0d got se=%b exp 1", c, store_executed);
            else n_pass++;
            tick();
        end
        set_store(32'h510, 32'h4, 3'b010);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_wr_ack = 1'b1;
            #1;
            n_total++;
            if (store_executed !== 1'b0 || sb_full !== 1'b1)
                $display("FAIL full_block%0d got se=%b full=%b exp 0 1", c, store_executed, sb_full);
            else n_pass++;
            tick();
        end
        mem_wr_ack = 1'b0;
        #1;
        n_total++;
        if (store_executed !== 1'b1 || sb_full !== 1'b0)
            $display("FAIL full_accept5 got se=%b full=%b exp 1 0", store_executed, sb_full);
        else n_pass++;
        tick();
        idle_in();
        mem_wr_ack = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            n_total++;
            if (mem_wr_en !== 1'b1 || mem_addr !== 32'h500 + 32'(4 * k))
                $display("FAIL full_drain%0d got wen=%b addr=%h exp 1 %h", k, mem_wr_en, mem_addr, 32'h500 + 32'(4 * k));
            else n_pass++;
            tick();
        end
        idle_in();
        #1;
        n_total++;
        if (sb_empty !== 1'b1 || mem_wr_en !== 1'b0)
            $display("FAIL full_empty got empty=%b wen=%b exp 1 0", sb_empty, mem_wr_en);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        idle_in();
        set_store(32'h40, 32'h11111111, 3'b010);
        tick();
        set_store(32'h40, 32'h22222222, 3'b010);
        tick();
        set_store(32'h41, 32'h00000077, 3'b000);
        ld_addr = 32'h40;
        #1;
        n_total++;
        if ({ld_fwd_hit, ld_fwd_conflict, ld_fwd_data} !== {2'b10, 32'h22222222})
            $display("FAIL fwd_youngest got hit=%b conf=%b data=%h exp 1 0 22222222",
                     ld_fwd_hit, ld_fwd_conflict, ld_fwd_data);
        else n_pass++;
        tick();
        idle_in();
        #1;
        n_total++;
        if ({ld_fwd_hit, ld_fwd_conflict, ld_fwd_data} !== {2'b01, 32'h0})
            $display("FAIL fwd_partial got hit=%b conf=%b data=%h exp 0 1 0",
                     ld_fwd_hit, ld_fwd_conflict, ld_fwd_data);
        else n_pass++;
        ld_addr = 32'h44;
        #1;
        n_total++;
        if ({ld_fwd_hit, ld_fwd_conflict, ld_fwd_data} !== 34'h0)
            $display("FAIL fwd_miss got hit=%b conf=%b data=%h exp 0 0 0",
                     ld_fwd_hit, ld_fwd_conflict, ld_fwd_data);
        else n_pass++;
        mem_wr_ack = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        idle_in();
        #1;
        n_total++;
        if (sb_empty !== 1'b1)
            $display("FAIL fwd_drain got empty=%b exp 1", sb_empty);
        else n_pass++;
    endtask

    task automatic test_wrap();
        idle_in();
        set_store(32'h600, 32'h0, 3'b010);
        tick();
        set_store(32'h604, 32'h1, 3'b010);
        tick();
        for (int k = 2; k < 10; k++) begin
            set_store(32'h600 + 32'(4 * k), 32'(k), 3'b010);
            mem_wr_ack = 1'b1;
            #1;
            n_total++;
            if (store_executed !== 1'b1 || mem_addr !== 32'h600 + 32'(4 * (k - 2)) || mem_wdata !== 32'(k - 2))
                $display("FAIL wrap_order%0d got se=%b addr=%h wd=%h exp 1 %h %h",
                         k, store_executed, mem_addr, mem_wdata, 32'h600 + 32'(4 * (k - 2)), 32'(k - 2));
            else n_pass++;
            tick();
        end
        idle_in();
        #1;
        n_total++;
        if (sb_empty !== 1'b0 || sb_full !== 1'b0)
            $display("FAIL wrap_count got empty=%b full=%b exp 0 0", sb_empty, sb_full);
        else n_pass++;
        mem_wr_ack = 1'b1;
        for (int k = 8; k < 10; k++) begin
            #1;
            n_total++;
            if (mem_addr !== 32'h600 + 32'(4 * k))
                $display("FAIL wrap_tail%0d got addr=%h exp %h", k, mem_addr, 32'h600 + 32'(4 * k));
            else n_pass++;
            tick();
        end
        idle_in();
        #1;
        n_total++;
        if (sb_empty !== 1'b1)
            $display("FAIL wrap_empty got empty=%b exp 1", sb_empty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            set_store(32'h700 + 32'(4 * c), 32'(c), 3'b010);
            tick();
        end
        idle_in();
        #1;
        n_total++;
        if (mem_wr_en !== 1'b1)
            $display("FAIL rstmid_busy got wen=%b exp 1", mem_wr_en);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_wr_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (mem_wr_en !== 1'b0 || sb_empty !== 1'b1)
                $display("FAIL rstmid_idle%0d got wen=%b empty=%b exp 0 1", c, mem_wr_en, sb_empty);
            else n_pass++;
            tick();
        end
        idle_in();
    endtask

    task automatic test_random();
        logic [105:0] got, exp;
        logic [33:0]  fw;
        ent_t         h;
        for (int c = 0; c < 400; c++) begin
            rst_n              = ($urandom_range(0, 63) != 0);
            retire_valid       = $urandom_range(0, 1);
            retire_store_ready = ($urandom_range(0, 3) != 0);
            retire_store_addr  = 32'($urandom_range(0, 63));
            retire_store_data  = $urandom;
            retire_func3       = 3'($urandom_range(0, 7));
            mem_wr_ack         = ($urandom_range(0, 2) == 0);
            ld_addr            = 32'($urandom_range(0, 63));
            #1;
            fw = model_fwd(ld_addr);
            if (sb.size() != 0) begin
                h = sb[0];
                exp = {retire_valid && retire_store_ready && (sb.size() < DEPTH), 1'b1,
                       h.wa, 2'b00, h.d, h.be, fw, 1'b0, sb.size() == DEPTH};
            end else begin
                exp = {retire_valid && retire_store_ready, 1'b0, 68'h0, fw, 1'b1, 1'b0};
            end
            got = {store_executed, mem_wr_en, mem_addr, mem_wdata, mem_byte_en,
                   ld_fwd_hit, ld_fwd_conflict, ld_fwd_data, sb_empty, sb_full};
            n_total++;
            if (got !== exp)
                $display("FAIL random cyc%0d got %h exp %h", c, got, exp);
            else n_pass++;
            tick();
        end
        rst_n = 1'b1;
        idle_in();
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_encoding();
        test_full();
        test_forwarding();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
